// File: rtl/lift_seq.sv
// lift_seq: sequencer for one 5/3 lifting pass over three pixel RAMs.
//
// It walks sample indices 0..len-1. For each index it reads l[i], r[i] and
// odd[i], computes either the predict or the update result, and writes that
// result back to odd[i]. The l and r RAMs are only ever read.
//
// Each index takes three states, RD -> CALC -> WR, so a pass lasts
// 1 + 3*len cycles from start to done.
//
// Parameters
//   AW  address width; RAM depth is 2**AW.
//   DW  sample width, signed two's complement.
//
// Ports
//   clk, rst_n        rising-edge clock and asynchronous active-low reset.
//   start             one-cycle pulse that begins a pass. It is sampled
//                     only in IDLE.
//   mode              0 = predict, 1 = update. Latched on an accepted start.
//   len               number of samples in the pass. Latched on an
//                     accepted start.
//   busy              high while the pass runs (RD, CALC and WR).
//   done              one-cycle pulse when the pass completes.
//   pix_addr_l/r/odd  RAM addresses. They hold their last value when idle.
//   pix_we_l/r        always 0.
//   pix_we_odd        write strobe for the odd RAM, high in WR only.
//   pix_din_odd       registered lifting result written into the odd RAM.
//   pix_dout_l/r/odd  synchronous RAM read data, valid one cycle after
//                     the address.
//
// Build option
//   LIFT_SEQ_SAT_EN   when defined, the result is clamped to the DW-bit
//                     signed range. Otherwise it wraps modulo 2**DW.
module lift_seq #(
  parameter int AW = 7,
  parameter int DW = 26
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          mode,
  input  logic [AW-1:0] len,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] pix_addr_l,
  output logic [AW-1:0] pix_addr_r,
  output logic [AW-1:0] pix_addr_odd,
  output logic          pix_we_l,
  output logic          pix_we_r,
  output logic          pix_we_odd,
  output logic [DW-1:0] pix_din_odd,
  input  logic [DW-1:0] pix_dout_l,
  input  logic [DW-1:0] pix_dout_r,
  input  logic [DW-1:0] pix_dout_odd
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_CALC,
    S_WR,
    S_DONE
  } state_t;

`ifdef LIFT_SEQ_SAT_EN
  // The result keeps two guard bits so that it can be clamped.
  localparam int RW = DW + 2;
  localparam logic signed [RW-1:0] SAT_MAX = {3'b000, {(DW-1){1'b1}}};
  localparam logic signed [RW-1:0] SAT_MIN = {3'b111, {(DW-1){1'b0}}};

  function automatic logic [DW-1:0] sat_res(input logic signed [RW-1:0] v);
    if (v > SAT_MAX)      return SAT_MAX[DW-1:0];
    else if (v < SAT_MIN) return SAT_MIN[DW-1:0];
    else                  return v[DW-1:0];
  endfunction
`else
  // Wrapping build: only the low DW bits of the result are kept.
  localparam int RW = DW;
`endif

  state_t                 state, state_nxt;
  logic                   mode_q;
  logic [AW-1:0]          len_q;
  logic [AW-1:0]          idx;
  logic [AW-1:0]          addr_q;
  logic                   last;
  logic signed [DW+1:0]   l_x, r_x, odd_x, sum_x, sum_rnd;
  logic signed [RW-1:0]   res_x;

  assign last = (idx == len_q - AW'(1));

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = (len == '0) ? S_DONE : S_RD;
      S_RD:   state_nxt = S_CALC;
      S_CALC: state_nxt = S_WR;
      S_WR:   state_nxt = last ? S_DONE : S_RD;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Lifting arithmetic. Operands are extended to DW+2 bits, so neither the
  // sum nor the rounding offset can overflow before the arithmetic shift.
  always_comb begin
    l_x     = $signed({{2{pix_dout_l[DW-1]}}, pix_dout_l});
    r_x     = $signed({{2{pix_dout_r[DW-1]}}, pix_dout_r});
    odd_x   = $signed({{2{pix_dout_odd[DW-1]}}, pix_dout_odd});
    sum_x   = l_x + r_x;
    sum_rnd = sum_x + $signed((DW+2)'(2));
    if (mode_q) res_x = RW'(odd_x + (sum_rnd >>> 2));
    else        res_x = RW'(odd_x - (sum_x >>> 1));
  end

  // State register and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      mode_q      <= 1'b0;
      len_q       <= '0;
      idx         <= '0;
      addr_q      <= '0;
      pix_din_odd <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (start) begin
            mode_q <= mode;
            len_q  <= len;
            idx    <= '0;
            // With len=0 no RAM is touched, so the addresses keep their
            // last value.
            if (len != '0) addr_q <= '0;
          end
        end
        S_CALC: begin
`ifdef LIFT_SEQ_SAT_EN
          pix_din_odd <= sat_res(res_x);
`else
          pix_din_odd <= res_x;
`endif
        end
        S_WR: begin
          if (!last) begin
            idx    <= idx + AW'(1);
            addr_q <= idx + AW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy         = (state == S_RD) || (state == S_CALC) || (state == S_WR);
  assign done         = (state == S_DONE);
  assign pix_we_odd   = (state == S_WR);
  assign pix_we_l     = 1'b0;
  assign pix_we_r     = 1'b0;
  assign pix_addr_l   = addr_q;
  assign pix_addr_r   = addr_q;
  assign pix_addr_odd = addr_q;

endmodule

// File: tb/tb_lift_seq.sv
// Testbench for lift_seq.
//
// The bench models the three RAMs with one-cycle synchronous reads. For each
// pass it predicts the complete list of odd-RAM writes and the cycle on which
// done should pulse, using plain integer arithmetic. A monitor compares the
// DUT's writes, done timing and busy level against those predictions.
module tb_lift_seq;
  localparam int AW    = 7;
  localparam int DW    = 26;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          mode = 1'b0;
  logic [AW-1:0] len = '0;
  logic          busy, done;
  logic [AW-1:0] pix_addr_l, pix_addr_r, pix_addr_odd;
  logic          pix_we_l, pix_we_r, pix_we_odd;
  logic [DW-1:0] pix_din_odd;
  logic [DW-1:0] pix_dout_l, pix_dout_r, pix_dout_odd;

  lift_seq #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .len(len),
    .busy(busy), .done(done),
    .pix_addr_l(pix_addr_l), .pix_addr_r(pix_addr_r), .pix_addr_odd(pix_addr_odd),
    .pix_we_l(pix_we_l), .pix_we_r(pix_we_r), .pix_we_odd(pix_we_odd),
    .pix_din_odd(pix_din_odd),
    .pix_dout_l(pix_dout_l), .pix_dout_r(pix_dout_r), .pix_dout_odd(pix_dout_odd)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAMs with synchronous read. Each read samples the old contents before
  // any write on the same edge.
  logic [DW-1:0] ram_l [DEPTH];
  logic [DW-1:0] ram_r [DEPTH];
  logic [DW-1:0] ram_odd [DEPTH];
  always @(posedge clk) begin
    pix_dout_l   <= ram_l[pix_addr_l];
    pix_dout_r   <= ram_r[pix_addr_r];
    pix_dout_odd <= ram_odd[pix_addr_odd];
    if (pix_we_odd) ram_odd[pix_addr_odd] = pix_din_odd;
  end

  typedef struct {
    int            addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t wq[$];
  int  dq[$];
  int  busy_lo = 1, busy_hi = 0;
  int  n_cmp = 0, n_fail = 0;
  int  last_n = 0, done_cyc = 0;

  task automatic chk(input string nm, input longint got, input longint exp);
    n_cmp++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // Floor division for a positive divisor.
  function automatic longint fdiv(input longint a, input longint b);
    longint q;
    q = a / b;
    if ((a % b != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  // Reference lifting step computed on plain integers.
  function automatic logic [DW-1:0] ref_res(input bit m, input logic [DW-1:0] l,
                                            input logic [DW-1:0] r, input logic [DW-1:0] o);
    longint sl, sr, so, s, res;
    sl = longint'($signed(l));
    sr = longint'($signed(r));
    so = longint'($signed(o));
    s  = sl + sr;
    if (m) res = so + fdiv(s + 2, 4);
    else   res = so - fdiv(s, 2);
`ifdef LIFT_SEQ_SAT_EN
    if (res > (longint'(1) << (DW-1)) - 1) res = (longint'(1) << (DW-1)) - 1;
    if (res < -(longint'(1) << (DW-1)))    res = -(longint'(1) << (DW-1));
`endif
    return res[DW-1:0];
  endfunction

  function automatic logic [DW-1:0] rnd_val();
    logic [DW-1:0] v;
    case ($urandom_range(0, 5))
      0:       v = {1'b1, {(DW-1){1'b0}}};
      1:       v = {1'b0, {(DW-1){1'b1}}};
      default: v = DW'($urandom);
    endcase
    return v;
  endfunction

  task automatic fill(input int n);
    for (int i = 0; i < n; i++) begin
      ram_l[i]   = rnd_val();
      ram_r[i]   = rnd_val();
      ram_odd[i] = rnd_val();
    end
  endtask

  // Pulse start and record the expected writes, done cycle and busy window.
  task automatic issue(input bit m, input int n);
    @(negedge clk);
    mode   = m;
    len    = AW'(n);
    start  = 1'b1;
    last_n = cyc;
    for (int i = 0; i < n; i++) begin
      wr_t e;
      e.addr = i;
      e.data = ref_res(m, ram_l[i], ram_r[i], ram_odd[i]);
      wq.push_back(e);
    end
    dq.push_back(cyc + 1 + 3 * n);
    busy_lo = cyc + 1;
    busy_hi = cyc + 3 * n;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Wait a bounded time for done. With inject set, pulse an ignored start
  // carrying different mode and len part-way through the pass.
  task automatic wait_done(input int n, input bit inject);
    bit got;
    got = 1'b0;
    for (int k = 0; k < 3 * n + 8; k++) begin
      @(negedge clk);
      if (inject && k == 3) begin
        start = 1'b1;
        len   = AW'(3);
        mode  = ~mode;
      end
      if (inject && k == 4) start = 1'b0;
      if (done) begin
        got      = 1'b1;
        done_cyc = cyc;
        break;
      end
    end
    if (!got) begin
      n_cmp++;
      n_fail++;
      $display("FAIL done_timeout: no done within %0d cycles, len=%0d", 3 * n + 8, n);
    end
  endtask

  // Monitor: compares busy, the write strobes, writes and done timing.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy", busy, (cyc >= busy_lo && cyc <= busy_hi));
      chk("we_lr", {pix_we_l, pix_we_r}, 0);
      if (pix_we_odd) begin
        if (wq.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_write: addr %0d data %0d, expected no write",
                   pix_addr_odd, pix_din_odd);
        end else begin
          wr_t e;
          e = wq.pop_front();
          chk("wr_addr", pix_addr_odd, e.addr);
          chk("wr_data", pix_din_odd, e.data);
        end
      end
      if (done) begin
        if (dq.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_done: done at cycle %0d, expected none", cyc);
        end else begin
          chk("done_cycle", cyc, dq.pop_front());
        end
        chk("writes_left_at_done", wq.size(), 0);
      end
    end
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      ram_l[i]   = '0;
      ram_r[i]   = '0;
      ram_odd[i] = '0;
    end
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_we_odd", pix_we_odd, 0);
    chk("rst_addr_l", pix_addr_l, 0);
    chk("rst_addr_odd", pix_addr_odd, 0);
    chk("rst_din", pix_din_odd, 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;

    // Directed cases.
    ram_l[0] = DW'(10); ram_r[0] = DW'(20); ram_odd[0] = DW'(100);
    issue(1'b0, 1); wait_done(1, 1'b0);
    chk("predict_len1", ram_odd[0], 85);
    chk("predict_len1_latency", done_cyc - last_n, 4);

    ram_odd[0] = DW'(100);
    issue(1'b1, 1); wait_done(1, 1'b0);
    chk("update_len1", ram_odd[0], 108);

    ram_l[0] = DW'(-3); ram_r[0] = DW'(-4); ram_odd[0] = '0;
    issue(1'b0, 1); wait_done(1, 1'b0);
    chk("predict_negative", ram_odd[0], 4);

    for (int i = 0; i < 5; i++) begin
      ram_l[i] = '0; ram_r[i] = '0; ram_odd[i] = DW'(i);
    end
    issue(1'b0, 5); wait_done(5, 1'b1);
    chk("len5_latency", done_cyc - last_n, 16);
    for (int i = 0; i < 5; i++) chk("len5_odd_unchanged", ram_odd[i], i);

    issue(1'b0, 0); wait_done(0, 1'b0);
    chk("len0_latency", done_cyc - last_n, 1);

    ram_l[0] = DW'(-33554432); ram_r[0] = DW'(-33554432); ram_odd[0] = DW'(33554431);
    issue(1'b0, 1); wait_done(1, 1'b0);
`ifdef LIFT_SEQ_SAT_EN
    chk("overflow_sat", ram_odd[0], 33554431);
`else
    chk("overflow_wrap", ram_odd[0], 'h3FFFFFF);
`endif

    // Randomized passes, then one at the maximum length.
    repeat (25) begin
      int n;
      bit m;
      n = $urandom_range(0, 24);
      m = 1'($urandom);
      fill(n);
      issue(m, n);
      wait_done(n, 1'b0);
    end
    fill(DEPTH - 1);
    issue(1'b1, DEPTH - 1); wait_done(DEPTH - 1, 1'b0);

    // Reset during CALC of a len=8 pass, then a normal len=2 pass.
    fill(8);
    issue(1'b0, 8);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_we_odd", pix_we_odd, 0);
    chk("midrst_done", done, 0);
    chk("midrst_addr_odd", pix_addr_odd, 0);
    wq.delete();
    dq.delete();
    busy_lo = 1;
    busy_hi = 0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    fill(2);
    issue(1'b1, 2); wait_done(2, 1'b0);
    chk("post_rst_latency", done_cyc - last_n, 7);

    repeat (2) @(negedge clk);
    chk("final_wq_empty", wq.size(), 0);
    chk("final_dq_empty", dq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/lift_seq.md
Name: lift_seq

Overview:
- Sequencer for one 5/3 lifting pass over the three pixel RAMs: left-even (l), right-even (r) and odd.
- Walks sample indices 0..len-1 and reads l[i], r[i] and odd[i].
- Computes the predict or update result and writes it back into odd[i].
- Owns the address and write-enable lines of all three RAMs while busy; the l and r RAMs are only ever read.

Parameters:
- AW, 7, address width; RAM depth is 2**AW.
- DW, 26, sample width, signed two's complement.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse that begins a pass; sampled only in IDLE.
- mode  in  1  0 = predict, 1 = update; latched on accepted start.
- len  in  AW  number of samples to process; latched on accepted start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the pass completes.
- pix_addr_l  out  AW  read address for the l RAM.
- pix_addr_r  out  AW  read address for the r RAM.
- pix_addr_odd  out  AW  read/write address for the odd RAM.
- pix_we_l  out  1  tied 0.
- pix_we_r  out  1  tied 0.
- pix_we_odd  out  1  write strobe for the odd RAM.
- pix_din_odd  out  DW  write data for the odd RAM.
- pix_dout_l  in  DW  read data, valid 1 cycle after address.
- pix_dout_r  in  DW  read data, valid 1 cycle after address.
- pix_dout_odd  in  DW  read data, valid 1 cycle after address.

Behaviour:
- RAM read latency is 1 clk (synchronous read); RAM write occurs on the clk edge where pix_we_odd=1.
- Reset (async, rst_n=0): state=IDLE, idx=0, all addresses 0, pix_we_odd=0, pix_din_odd=0, busy=0, done=0. This applies at any time, including mid-pass; a write in flight is dropped.
- FSM states:
  - IDLE: start=1 -> latch mode and len, idx=0.
    - len=0 -> DONE.
    - Otherwise -> RD.
  - RD: drive all three addresses = idx, we=0 -> CALC.
  - CALC: RAM data is valid.
    - s = sext(l) + sext(r), DW+1 bits.
    - Predict: res = odd - (s >>> 1).
    - Update: res = odd + ((s + 2) >>> 2).
    - Register res into pix_din_odd -> WR.
  - WR: pix_we_odd=1, pix_addr_odd=idx.
    - idx == len-1 -> DONE.
    - Otherwise idx++ -> RD.
  - DONE: done=1 for exactly one cycle, busy=0 -> IDLE.
- All shifts are arithmetic. Without saturation, the result is truncated to the low DW bits (wrap).
- busy=1 in RD, CALC and WR only.
- Cycles from start to done pulse: 1 + 3*len. For len=0, done comes 1 cycle after start.
- pix_we_odd is asserted only in WR, exactly len times per pass.
- Addresses hold their last value outside RD/WR.
- start while busy or in DONE is ignored; it is not queued.
- mode and len changing during a pass have no effect.
- Index never wraps: len ≤ 2**AW-1, and idx stops at len-1.

Optional Feature:
- Macro: LIFT_SEQ_SAT_EN.
- Defined: res is computed in DW+2 bits and clamped to [-2**(DW-1), 2**(DW-1)-1] before it is registered.
- Undefined: res wraps modulo 2**DW.
- All other timing is identical in both builds.

Test Plan:
- Predict, len=1, l[0]=10, r[0]=20, odd[0]=100 -> odd[0]=85; done 4 cycles after start; one we_odd pulse.
- Update, len=1, same data -> odd[0]=108. Negative case: predict with l=-3, r=-4, odd=0 -> odd=4.
- Predict, len=5, odd[i]=i, l=r=0 -> odd unchanged; 5 we_odd pulses at addresses 0..4; done at cycle 16; start pulsed mid-pass is ignored.
- len=0 -> done 1 cycle after start, no we_odd, busy never high.
- Overflow: predict, l=r=-33554432, odd=33554431 -> without macro odd=-1 (0x3FFFFFF); with LIFT_SEQ_SAT_EN, odd=33554431.
- rst_n low during CALC of a len=8 pass -> we_odd=0, busy=0 immediately; a subsequent start with len=2 completes normally in 7 cycles.
